// File: rtl/mult_sched.sv
// mult_sched: round-robin front end sharing one 2-stage pipelined
// signed multiplier among NREQ requesters, with a WAIT-state watchdog.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_a/req_b
// request side (operand i at [i*WIDTH +: WIDTH]); resp_valid/resp_ready/
// resp_data/resp_err response side; mul_in_valid/mul_a/mul_b/mul_o/
// mul_out_valid multiplier side; busy; op_count (completed responses).
module mult_sched #(
  parameter int WIDTH   = 64,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_err,
  output logic                  mul_in_valid,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [WIDTH-1:0]      mul_o,
  input  logic                  mul_out_valid,
  output logic                  busy,
  output logic [15:0]           op_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    ISSUE1,
    WAIT,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    g_q;
  logic [CW-1:0]    wd_q;
  logic [15:0]      cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;

  logic             gnt_hit;
  logic [IW-1:0]    gnt_idx;
  logic [IW:0]      sum;
  logic [IW-1:0]    idx;
  logic             grant;
  logic             hs;

  // Search upward from rr_q with wrap; first valid requester wins.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      idx = sum[IW-1:0];
      if (!gnt_hit && req_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign grant = (state_q == IDLE) && gnt_hit;
  assign hs    = (state_q == RESP) && resp_ready[g_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (gnt_hit) state_d = ISSUE0;
      ISSUE0: state_d = ISSUE1;
      ISSUE1: state_d = WAIT;
      WAIT: begin
        if (mul_out_valid || (wd_q == TO_LAST)) begin
          state_d = RESP;
        end
      end
      RESP:   if (resp_ready[g_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        a_q  <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        b_q  <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        g_q  <= gnt_idx;
        rr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == ISSUE1) begin
        wd_q <= '0;
      end else if (state_q == WAIT) begin
        wd_q <= wd_q + 1'b1;
      end
      // A real result beats a timeout landing on the same cycle.
      if (state_q == WAIT) begin
        if (mul_out_valid) begin
          data_q <= mul_o;
          err_q  <= 1'b0;
        end else if (wd_q == TO_LAST) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
      if (hs) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign req_ready    = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign resp_valid   = (state_q == RESP) ? (NREQ'(1) << g_q) : '0;
  assign resp_data    = data_q;
  assign resp_err     = err_q;
  assign mul_in_valid = (state_q == ISSUE0) || (state_q == ISSUE1);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign busy         = (state_q != IDLE);
  assign op_count     = cnt_q;

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Round-robin scheduler that shares one two-stage pipelined signed multiplier (WIDTH-bit, truncated product) among NREQ requesters in the non-linear-ops datapath.
- Accepts operand pairs over valid/ready, drives the multiplier with its required hold-two-cycles issue protocol, and captures the product.
- Returns each product to the requester that issued it over a per-requester valid/ready response channel.
- Includes a watchdog so a lost multiplier out_valid cannot hang the block.

Parameters:
- WIDTH, 64: operand/product width.
- NREQ, 4: number of requesters, ≥2.
- TIMEOUT, 8: max cycles in WAIT before abort, ≥3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  operand request per requester.
- req_ready  out  NREQ  one-hot grant/accept, combinational.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing.
- resp_valid  out  NREQ  one-hot response valid.
- resp_ready  in  NREQ  response accept per requester.
- resp_data  out  WIDTH  product of the current response.
- resp_err  out  1  current response is a watchdog abort; resp_data is 0 in that case.
- mul_in_valid  out  1  to multiplier in_valid.
- mul_a  out  WIDTH  to multiplier operand 1.
- mul_b  out  WIDTH  to multiplier operand 2.
- mul_o  in  WIDTH  from multiplier result.
- mul_out_valid  in  1  from multiplier out_valid.
- busy  out  1  high whenever state ≠ IDLE.
- op_count  out  16  completed responses (including error responses); wraps at 2^16.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, op_count=0, every registered output 0. In IDLE with no requests, req_ready=0.
- Reset mid-operation aborts silently; no response is produced.
- Multiplier contract:
  - Operands must be stable with in_valid high for 2 consecutive cycles, then in_valid low.
  - Product is valid on mul_o when mul_out_valid pulses, 2 cycles after the first in_valid cycle.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid high, searching from rr pointer upward with wrap.
  - req_ready[g]=1 combinationally in that same cycle.
  - On that edge, latch a/b/g, set rr pointer to (g+1) mod NREQ, and go to ISSUE0.
- ISSUE0 → ISSUE1 → WAIT:
  - mul_in_valid=1 in both issue states, with mul_a/mul_b driven from the latched operands (registered outputs).
  - mul_a/mul_b hold the latched values through WAIT.
  - mul_in_valid=0 in all other states.
- WAIT:
  - Watchdog counter clears on WAIT entry.
  - If mul_out_valid=1: capture mul_o into resp_data, resp_err=0, go to RESP.
  - Else if the counter reaches TIMEOUT-1: resp_data=0, resp_err=1, go to RESP.
  - If mul_out_valid arrives on the same cycle as the timeout, the valid result wins.
- RESP:
  - resp_valid[g]=1, all other resp_valid bits 0.
  - resp_data and resp_err are held stable until resp_ready[g]=1; resp_ready bits of other requesters are ignored.
  - On handshake: op_count increments, next state IDLE, resp_valid drops the following cycle.
- Any mul_out_valid pulse outside WAIT is ignored.
- No new grant is given while the block is busy, so there is exactly one outstanding op.
- Minimum turnaround: grant cycle, ISSUE0, ISSUE1, WAIT, RESP, i.e. 5 cycles from grant to response handshake when resp_ready is held high.
- Fairness: a requester with req_valid held high is granted within NREQ ops.
- A requester may deassert req_valid before it is granted; no grant is issued for that request.
- Arithmetic: no arithmetic is done in this block; products are passed through bit-exact.

Test Plan:
- Single requester 2: a=7, b=-3 → mul_in_valid high exactly 2 cycles with 7/-3; resp_valid=4'b0100, resp_data=-21, resp_err=0; op_count=1.
- All 4 requesters valid continuously, resp_ready=4'hF → grant order 0,1,2,3,0,…; rr pointer wraps; each response matches its own operands; one op every 5 cycles.
- Requester 1 in RESP with resp_ready[1]=0 for 10 cycles while req_valid[3]=1 → resp_data stable, no new mul_in_valid, req_ready=0; grant to 3 only after the handshake.
- Multiplier model drops mul_out_valid → after TIMEOUT cycles in WAIT, resp_valid asserts with resp_err=1 and resp_data=0; the next op completes normally.
- Spurious mul_out_valid pulse in IDLE → no response, state stays IDLE.
- rst asserted during WAIT → outputs 0 immediately (async); after release, a fresh request completes with op_count=1.
- op_count preloaded near wrap by running 65536 ops (or forced) → count wraps 0xFFFF → 0x0000.
